// File: rtl/real_clock_pkg.sv
// real_clock_pkg: shared constants and helpers for the real-time clock and its capture slots.
package real_clock_pkg;

    localparam logic [9:0] US_MAX = 10'd999;
    localparam logic [9:0] MS_MAX = 10'd999;

    function automatic int clogb2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int ts_w(input int sec_w);
        return sec_w + 20;
    endfunction

    function automatic logic [9:0] clamp(input logic [9:0] v, input logic [9:0] max);
        return v > max ? max : v;
    endfunction

endpackage

// File: rtl/ts_capture_slot.sv
// ts_capture_slot: one timestamp holding register with valid/overflow handshake.
module ts_capture_slot #(
    parameter int TS_W = 52
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req,
    input  logic            ack,
    input  logic [TS_W-1:0] ts_in,
    output logic            valid,
    output logic            ovf,
    output logic [TS_W-1:0] ts
);

    logic            take;
    logic            valid_q, valid_d, ovf_q, ovf_d;
    logic [TS_W-1:0] ts_q, ts_d;

    // A same-cycle ack frees the slot, so a request alongside it recaptures.
    always_comb begin
        take    = req && (!valid_q || ack);
        valid_d = take || (valid_q && !ack);
        ovf_d   = valid_q && !ack && (req || ovf_q);
        ts_d    = take ? ts_in : ts_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            ts_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            ts_q    <= ts_d;
        end
    end

    assign valid = valid_q;
    assign ovf   = ovf_q;
    assign ts    = ts_q;

endmodule

// File: rtl/real_clock_ts.sv
// real_clock_ts: sec/ms/us time-of-day counter with per-channel timestamp capture.
// Define REAL_CLOCK_TS_PPS_EN to generate the pulse-per-second output.
module real_clock_ts
    import real_clock_pkg::*;
#(
    parameter int CLOCK_PERIOD_NS = 10,
    parameter int SEC_W           = 32,
    parameter int N_CH            = 4,
    parameter int PPS_WIDTH_MS    = 100
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        set_en,
    input  logic [SEC_W-1:0]            set_sec,
    input  logic [9:0]                  set_ms,
    input  logic [9:0]                  set_us,
    output logic [SEC_W-1:0]            time_sec,
    output logic [9:0]                  time_ms,
    output logic [9:0]                  time_us,
    output logic                        pps,
    input  logic [N_CH-1:0]             cap_req,
    input  logic [N_CH-1:0]             cap_ack,
    output logic [N_CH-1:0]             cap_valid,
    output logic [N_CH-1:0]             cap_ovf,
    output logic [N_CH*ts_w(SEC_W)-1:0] cap_ts
);

    localparam int US_CYCLES = 1000 / CLOCK_PERIOD_NS;
    localparam int SUB_W     = clogb2(US_CYCLES);
    localparam int TS_W      = ts_w(SEC_W);

    if (1000 % CLOCK_PERIOD_NS != 0 || SEC_W < 16 || SEC_W > 48 || N_CH < 1 || N_CH > 16 ||
        PPS_WIDTH_MS < 1 || PPS_WIDTH_MS > 999) begin : g_bad_param
        $error("real_clock_ts: parameter out of range");
    end

    logic [SUB_W-1:0] sub_q, sub_d;
    logic [9:0]       us_q, us_d, ms_q, ms_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic             us_tick, ms_tick, sec_tick;

    // A load overrides every tick and restarts the microsecond phase.
    always_comb begin
        us_tick  = sub_q == SUB_W'(US_CYCLES - 1);
        ms_tick  = us_tick && us_q == US_MAX;
        sec_tick = ms_tick && ms_q == MS_MAX;
        sub_d    = set_en || us_tick ? '0 : sub_q + 1'b1;
        us_d     = set_en ? clamp(set_us, US_MAX) : ms_tick ? '0 : us_q + 10'(us_tick);
        ms_d     = set_en ? clamp(set_ms, MS_MAX) : sec_tick ? '0 : ms_q + 10'(ms_tick);
        sec_d    = set_en ? set_sec : sec_q + SEC_W'(sec_tick);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= '0;
            us_q  <= '0;
            ms_q  <= '0;
            sec_q <= '0;
        end else begin
            sub_q <= sub_d;
            us_q  <= us_d;
            ms_q  <= ms_d;
            sec_q <= sec_d;
        end
    end

    assign time_sec = sec_q;
    assign time_ms  = ms_q;
    assign time_us  = us_q;

`ifdef REAL_CLOCK_TS_PPS_EN
    logic pps_q, pps_d;

    always_comb pps_d = ms_q < 10'(PPS_WIDTH_MS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pps_q <= 1'b0;
        else        pps_q <= pps_d;
    end

    assign pps = pps_q;
`else
    assign pps = 1'b0;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_slot
        ts_capture_slot #(.TS_W(TS_W)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (cap_req[i]),
            .ack   (cap_ack[i]),
            .ts_in ({sec_q, ms_q, us_q}),
            .valid (cap_valid[i]),
            .ovf   (cap_ovf[i]),
            .ts    (cap_ts[i*TS_W +: TS_W])
        );
    end

endmodule

// File: tb/tb_real_clock_ts.sv
// tb_real_clock_ts: vector table, directed corner sequences and a randomized run against a
// total-microseconds reference model.
module tb_real_clock_ts;

    localparam int SEC_W = 32;
    localparam int N_CH  = 4;
    localparam int TS_W  = SEC_W + 20;
    localparam int UC    = 100;
    localparam int PPS_W = 100;
`ifdef REAL_CLOCK_TS_PPS_EN
    localparam bit PPS_ON = 1'b1;
`else
    localparam bit PPS_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 set_en;
    logic [SEC_W-1:0]     set_sec;
    logic [9:0]           set_ms, set_us;
    logic [SEC_W-1:0]     time_sec;
    logic [9:0]           time_ms, time_us;
    logic                 pps;
    logic [N_CH-1:0]      cap_req, cap_ack, cap_valid, cap_ovf;
    logic [N_CH*TS_W-1:0] cap_ts;

    logic        set_en2;
    logic [15:0] set_sec2, time_sec2;
    logic [9:0]  set_ms2, set_us2, time_ms2, time_us2;
    logic        pps2;
    logic [0:0]  cap_req2, cap_ack2, cap_valid2, cap_ovf2;
    logic [35:0] cap_ts2;

    always #5 clk = ~clk;

    real_clock_ts dut (
        .clk(clk), .rst_n(rst_n), .set_en(set_en), .set_sec(set_sec), .set_ms(set_ms),
        .set_us(set_us), .time_sec(time_sec), .time_ms(time_ms), .time_us(time_us), .pps(pps),
        .cap_req(cap_req), .cap_ack(cap_ack), .cap_valid(cap_valid), .cap_ovf(cap_ovf),
        .cap_ts(cap_ts)
    );

    real_clock_ts #(.SEC_W(16), .N_CH(1)) dut16 (
        .clk(clk), .rst_n(rst_n), .set_en(set_en2), .set_sec(set_sec2), .set_ms(set_ms2),
        .set_us(set_us2), .time_sec(time_sec2), .time_ms(time_ms2), .time_us(time_us2),
        .pps(pps2), .cap_req(cap_req2), .cap_ack(cap_ack2), .cap_valid(cap_valid2),
        .cap_ovf(cap_ovf2), .cap_ts(cap_ts2)
    );

    // Reference: time is a running microsecond total = loaded value + elapsed cycles / UC.
    longint          m_base, m_n;
    logic            m_valid[N_CH], m_ovf[N_CH], m_pps;
    logic [TS_W-1:0] m_ts[N_CH];

    function automatic longint sat(input logic [9:0] v);
        return v > 10'd999 ? 64'd999 : longint'(v);
    endfunction

    function automatic logic [TS_W-1:0] exp_ts();
        longint t;
        t = m_base + m_n / UC;
        return {SEC_W'(t / 1000000), 10'((t / 1000) % 1000), 10'(t % 1000)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_base <= 0;
            m_n    <= 0;
            m_pps  <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                m_valid[i] <= 1'b0;
                m_ovf[i]   <= 1'b0;
                m_ts[i]    <= '0;
            end
        end else begin
            m_pps <= exp_ts()[19:10] < 10'(PPS_W);
            if (set_en) begin
                m_base <= longint'(set_sec) * 1000000 + sat(set_ms) * 1000 + sat(set_us);
                m_n    <= 0;
            end else begin
                m_n <= m_n + 1;
            end
            for (int i = 0; i < N_CH; i++) begin
                if (cap_req[i] && (!m_valid[i] || cap_ack[i])) begin
                    m_ts[i]    <= exp_ts();
                    m_valid[i] <= 1'b1;
                    m_ovf[i]   <= 1'b0;
                end else if (cap_req[i]) begin
                    m_ovf[i] <= 1'b1;
                end else if (cap_ack[i]) begin
                    m_valid[i] <= 1'b0;
                    m_ovf[i]   <= 1'b0;
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [31:0] s, input logic [9:0] m, input logic [9:0] u);
        set_en = 1'b1; set_sec = s; set_ms = m; set_us = u;
        @(negedge clk);
        set_en = 1'b0;
    endtask

    task automatic pulse(input logic [N_CH-1:0] r, input logic [N_CH-1:0] a);
        cap_req = r; cap_ack = a;
        @(negedge clk);
        cap_req = '0; cap_ack = '0;
    endtask

    function automatic logic [TS_W-1:0] slot(input int i);
        return cap_ts[i*TS_W +: TS_W];
    endfunction

    task automatic chk_time(input string name, input logic [31:0] s, input logic [9:0] m,
                            input logic [9:0] u);
        chk(name, {time_sec, time_ms, time_us}, {s, m, u});
    endtask

    task automatic chk_model();
        logic [N_CH-1:0] ev, eo;
        for (int i = 0; i < N_CH; i++) begin
            ev[i] = m_valid[i];
            eo[i] = m_ovf[i];
            chk($sformatf("rnd_ts%0d", i), slot(i), m_ts[i]);
        end
        chk("rnd_time", {time_sec, time_ms, time_us}, exp_ts());
        chk("rnd_pps", pps, PPS_ON ? m_pps : 1'b0);
        chk("rnd_valid", cap_valid, ev);
        chk("rnd_ovf", cap_ovf, eo);
    endtask

    typedef struct {
        logic [31:0] sec;
        logic [9:0]  ms, us;
        int          n;
        logic [31:0] esec;
        logic [9:0]  ems, eus;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{32'd5, 10'd999, 10'd999, 100, 32'd6, 10'd0, 10'd0};
        tbl[1] = '{32'd5, 10'd999, 10'd999, 99, 32'd5, 10'd999, 10'd999};
        tbl[2] = '{32'd7, 10'd1023, 10'd5, 0, 32'd7, 10'd999, 10'd5};
        tbl[3] = '{32'd0, 10'd0, 10'd998, 200, 32'd0, 10'd1, 10'd0};
        tbl[4] = '{32'hFFFF_FFFF, 10'd999, 10'd999, 100, 32'd0, 10'd0, 10'd0};
        tbl[5] = '{32'd3, 10'd500, 10'd1000, 150, 32'd3, 10'd501, 10'd0};
        tbl[6] = '{32'd9, 10'd1000, 10'd0, 99, 32'd9, 10'd999, 10'd0};

        set_en = 1'b1; set_sec = 32'd123; set_ms = 10'd4; set_us = 10'd5;
        cap_req = '1; cap_ack = '0;
        set_en2 = 1'b0; set_sec2 = '0; set_ms2 = '0; set_us2 = '0;
        cap_req2 = '0; cap_ack2 = '0;

        // Reset dominates active load and capture inputs.
        tick(3);
        chk_time("rst_time", 32'd0, 10'd0, 10'd0);
        chk("rst_pps", pps, 1'b0);
        chk("rst_valid", cap_valid, '0);
        chk("rst_ovf", cap_ovf, '0);
        chk("rst_ts", cap_ts == '0, 1'b1);
        set_en = 1'b0; cap_req = '0;
        rst_n = 1'b1;
        tick(99);
        chk_time("rel_99", 32'd0, 10'd0, 10'd0);
        tick(1);
        chk_time("rel_100", 32'd0, 10'd0, 10'd1);

        for (int k = 0; k < 7; k++) begin
            load(tbl[k].sec, tbl[k].ms, tbl[k].us);
            tick(tbl[k].n);
            chk_time($sformatf("tbl%0d", k), tbl[k].esec, tbl[k].ems, tbl[k].eus);
        end

        load(32'd5, 10'd999, 10'd999);
        tick(100);
        chk_time("pps_time", 32'd6, 10'd0, 10'd0);
        chk("pps_pre", pps, 1'b0);
        tick(1);
        chk("pps_rise", pps, PPS_ON);

        // Load coinciding with a ms_tick: load wins and the us phase restarts.
        load(32'd1, 10'd5, 10'd999);
        tick(99);
        load(32'd2, 10'd1023, 10'd3);
        chk_time("prio_load", 32'd2, 10'd999, 10'd3);
        tick(99);
        chk("prio_sub99", time_us, 10'd3);
        tick(1);
        chk("prio_sub100", time_us, 10'd4);

        load(32'd7, 10'd12, 10'd300);
        pulse(4'b0100, 4'b0000);
        chk("cap2_ts", slot(2), {32'd7, 10'd12, 10'd300});
        chk("cap2_valid", cap_valid, 4'b0100);
        chk("cap2_ovf", cap_ovf, 4'b0000);
        tick(250);
        load(32'd1, 10'd2, 10'd3);
        chk("set_keeps_slot", slot(2), {32'd7, 10'd12, 10'd300});
        pulse(4'b0100, 4'b0000);
        chk("ovf2_set", cap_ovf, 4'b0100);
        chk("ovf2_slot", slot(2), {32'd7, 10'd12, 10'd300});
        tick(5);
        chk("ovf2_sticky", cap_ovf, 4'b0100);
        pulse(4'b0000, 4'b0100);
        chk("ack2_valid", cap_valid, 4'b0000);
        chk("ack2_ovf", cap_ovf, 4'b0000);
        pulse(4'b0000, 4'b0100);
        chk("ack_idle", {cap_valid, cap_ovf}, 8'h00);

        load(32'd10, 10'd0, 10'd0);
        pulse(4'b0001, 4'b0000);
        chk("cap0_ts", slot(0), {32'd10, 10'd0, 10'd0});
        tick(99);
        pulse(4'b0001, 4'b0000);
        chk("cap0_ovf", cap_ovf, 4'b0001);
        pulse(4'b0001, 4'b0001);
        chk("recap_ts", slot(0), {32'd10, 10'd0, 10'd1});
        chk("recap_valid", cap_valid, 4'b0001);
        chk("recap_ovf", cap_ovf, 4'b0000);

        // Asynchronous reset mid-count with a slot held.
        #2 rst_n = 1'b0;
        #1;
        chk_time("arst_time", 32'd0, 10'd0, 10'd0);
        chk("arst_cap", {cap_valid, cap_ovf, |cap_ts}, 9'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(100);
        chk_time("arst_restart", 32'd0, 10'd0, 10'd1);

        set_en2 = 1'b1; set_sec2 = 16'hFFFF; set_ms2 = 10'd999; set_us2 = 10'd999;
        @(negedge clk);
        set_en2 = 1'b0;
        chk("w16_load", {time_sec2, time_ms2, time_us2}, {16'hFFFF, 10'd999, 10'd999});
        tick(100);
        chk("w16_wrap", {time_sec2, time_ms2, time_us2}, 36'd0);

        for (int c = 0; c < 3000; c++) begin
            chk_model();
            set_en = $urandom_range(0, 63) == 0;
            set_sec = $urandom;
            set_ms = $urandom_range(0, 1) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 1023));
            set_us = $urandom_range(0, 1) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 1023));
            for (int i = 0; i < N_CH; i++) begin
                cap_req[i] = $urandom_range(0, 3) == 0;
                cap_ack[i] = $urandom_range(0, 3) == 0;
            end
            @(negedge clk);
        end
        set_en = 1'b0; cap_req = '0; cap_ack = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/real_clock_ts.md
REAL_CLOCK_TS -- requirements
Module: real_clock_ts

Interface
REQ-001 Parameter CLOCK_PERIOD_NS, default 10: clk period in ns; 1000 SHALL be an exact multiple of it.
REQ-002 Parameter SEC_W, default 32: seconds counter width, 16..48.
REQ-003 Parameter N_CH, default 4: number of timestamp capture channels, 1..16.
REQ-004 Parameter PPS_WIDTH_MS, default 100: PPS pulse width in ms, 1..999.
REQ-005 clk  input  1: single system clock; all logic on the rising edge.
REQ-006 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-007 set_en  input  1: one-cycle load strobe for the time counters.
REQ-008 set_sec / set_ms / set_us  input  SEC_W / 10 / 10: time value to load.
REQ-009 time_sec / time_ms / time_us  output  SEC_W / 10 / 10: current time.
REQ-010 pps  output  1: pulse-per-second.
REQ-011 cap_req  input  N_CH: per-channel one-cycle capture strobe.
REQ-012 cap_ack  input  N_CH: per-channel consumer acknowledge.
REQ-013 cap_valid / cap_ovf  output  N_CH / N_CH: capture held / request lost.
REQ-014 cap_ts  output  N_CH*TS_W, TS_W=SEC_W+20: packed {sec,ms,us} per channel, channel 0 in the LSBs.

Function
REQ-015 Sub-counter SHALL count 0..US_CYCLES-1 (US_CYCLES=1000/CLOCK_PERIOD_NS); us_tick is asserted on the terminal count.
REQ-016 time_us SHALL step 0..999 on us_tick; at 999 it wraps to 0 and raises ms_tick in the same cycle.
REQ-017 time_ms SHALL step 0..999 on ms_tick; at 999 it wraps and time_sec increments.
REQ-018 time_sec SHALL wrap modulo 2^SEC_W with no flag.
REQ-019 set_en SHALL take priority over any tick in the same cycle; the next cycle shows the loaded values and the sub-counter is 0.
REQ-020 Loaded set_ms or set_us values above 999 SHALL saturate to 999.
REQ-021 On cap_req[i]: if cap_valid[i]=0, or cap_ack[i]=1 in the same cycle, the ms/us/sec values present in that cycle (before update) SHALL be latched into slot i, with cap_valid[i]=1 on the next cycle.
REQ-022 On cap_req[i] while cap_valid[i]=1 and cap_ack[i]=0: the slot contents SHALL be unchanged and cap_ovf[i] set; cap_ovf[i] is sticky.
REQ-023 cap_ack[i] SHALL clear cap_valid[i] and cap_ovf[i] on the next edge, unless a same-cycle cap_req[i] recaptures, in which case cap_valid stays 1 and cap_ovf clears.
REQ-024 cap_ack[i] with cap_valid[i]=0 SHALL be ignored.
REQ-025 set_en SHALL NOT alter capture slots.

Reset
REQ-026 While rst_n=0: sub-counter, time_us, time_ms, time_sec, pps, cap_valid, cap_ovf and all cap_ts SHALL be 0.
REQ-027 Reset asserted mid-count or mid-capture SHALL abort immediately; counting restarts from 0 on the first edge after release.

Configuration
REQ-028 With macro REAL_CLOCK_TS_PPS_EN defined: pps=1 whenever time_ms < PPS_WIDTH_MS, registered, so it rises the cycle after the second rollover or a load.
REQ-029 Without REAL_CLOCK_TS_PPS_EN: pps is tied to 0 and no PPS logic is generated; all other behaviour is identical.

Structure
REQ-030 Shared package real_clock_pkg SHALL hold the clogb2 function, the constant 999 (US_MAX/MS_MAX) and the TS_W computation.
REQ-031 One sub-module, ts_capture_slot (one instance per channel, generate loop), SHALL implement REQ-021..REQ-024.

Verification
REQ-032 Reset release, CLOCK_PERIOD_NS=10: time_us=1 after 100 cycles; time_ms=1 after 100000 cycles.
REQ-033 Load sec=5, ms=999, us=999, then run 100 cycles: time = 6 s, 0 ms, 0 us; pps=1 one cycle later (macro defined), or pps=0 throughout (macro undefined).
REQ-034 set_en with set_ms=1023 in the same cycle as a ms_tick: time_ms=999 and sub-counter 0 on the next cycle.
REQ-035 cap_req[2] at time 7 s/12 ms/300 us: cap_ts slot 2 = {7,12,300} and cap_valid[2]=1 on the next cycle; a second cap_req[2] before ack gives cap_ovf[2]=1 with the slot unchanged.
REQ-036 Same-cycle cap_req[0] and cap_ack[0] with cap_valid[0]=1: new value captured, cap_valid[0] stays 1, cap_ovf[0]=0.
REQ-037 SEC_W=16, load sec=65535 ms=999 us=999: after 100 cycles, time_sec=0.
